// File: rtl/qam_demod.sv
// 4-point QAM demodulator: correlates rx samples against the local sin/cos
// reference over each 128-sample symbol, decides the symbol and tracks frame/gap state.
module qam_demod #(
    parameter int DATA_W     = 9,
    parameter int PHASE_W    = 7,
    parameter int ACC_W      = 25,
    parameter int ENERGY_TH  = 2048,
    parameter int FRAME_SYMS = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic signed [DATA_W-1:0] rx_in,
    input  logic signed [DATA_W-1:0] GetSin,
    input  logic signed [DATA_W-1:0] GetCos,
    output logic [1:0]               conv_out,
    output logic                     conv_valid,
    output logic [5:0]               sym_idx,
    output logic                     frame_start,
    output logic                     in_gap,
    output logic                     frame_err
);

    typedef enum logic [1:0] {SYNC, DATA, GAP} state_t;

    localparam logic [5:0] LAST_IDX = 6'(FRAME_SYMS - 1);

    logic [PHASE_W-1:0]         r_phase;
    logic signed [ACC_W-1:0]    r_i_acc;
    logic signed [ACC_W-1:0]    r_q_acc;
    logic [ACC_W-1:0]           r_e_acc;
    state_t                     r_state;
    logic [5:0]                 r_cnt;
    logic [1:0]                 r_conv_out;
    logic                       r_conv_valid;
    logic [5:0]                 r_sym_idx;
    logic                       r_frame_start;
    logic                       r_frame_err;

    logic signed [2*DATA_W-1:0] w_i_prod;
    logic signed [2*DATA_W-1:0] w_q_prod;
    logic signed [DATA_W:0]     w_rx_ext;
    logic [DATA_W:0]            w_rx_abs;
    logic                       w_first;
    logic                       w_last;
    logic signed [ACC_W-1:0]    w_i_sum;
    logic signed [ACC_W-1:0]    w_q_sum;
    logic [ACC_W-1:0]           w_e_sum;
    logic                       w_silent;
    logic [1:0]                 w_sym;
    state_t                     w_state_nxt;
    logic [5:0]                 w_cnt_nxt;
    logic                       w_emit;
    logic                       w_start;
    logic                       w_err;
    logic [5:0]                 w_idx;

    assign w_i_prod = rx_in * GetCos;
    assign w_q_prod = rx_in * GetSin;
    // One extra bit so that |-256| = 256 is representable.
    assign w_rx_ext = {rx_in[DATA_W-1], rx_in};
    assign w_rx_abs = w_rx_ext[DATA_W] ? unsigned'(-w_rx_ext) : unsigned'(w_rx_ext);

    assign w_first = (r_phase == '0);
    assign w_last  = &r_phase;

    // Phase 0 restarts from its own sample, so symbols run back to back with no idle cycle.
    assign w_i_sum = (w_first ? '0 : r_i_acc) + ACC_W'(w_i_prod);
    assign w_q_sum = (w_first ? '0 : r_q_acc) + ACC_W'(w_q_prod);
    assign w_e_sum = (w_first ? '0 : r_e_acc) + ACC_W'(w_rx_abs);

    assign w_silent = (w_e_sum < ACC_W'(ENERGY_TH));
    assign w_sym    = {(w_i_sum < 0), (w_q_sum > 0)};

    always_ff @(posedge clk or negedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!reset) begin
            r_phase <= '0;
            r_i_acc <= '0;
            r_q_acc <= '0;
            r_e_acc <= '0;
        end else begin
            r_phase <= r_phase + 1'b1;
            r_i_acc <= w_i_sum;
            r_q_acc <= w_q_sum;
            r_e_acc <= w_e_sum;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_emit      = 1'b0;
        w_start     = 1'b0;
        w_err       = 1'b0;
        w_idx       = r_cnt;
        if (w_last) begin
            case (r_state)
                SYNC, GAP: begin
                    if (!w_silent) begin
                        w_emit      = 1'b1;
                        w_start     = 1'b1;
                        w_idx       = '0;
                        w_cnt_nxt   = 6'd1;
                        w_state_nxt = DATA;
                    end
                end
                DATA: begin
                    if (w_silent) begin
                        w_err       = 1'b1;
                        w_cnt_nxt   = '0;
                        w_state_nxt = SYNC;
                    end else begin
                        w_emit    = 1'b1;
                        w_idx     = r_cnt;
                        w_cnt_nxt = r_cnt + 1'b1;
                        if (r_cnt == LAST_IDX) begin
                            w_state_nxt = GAP;
                        end
                    end
                end
                default: w_state_nxt = SYNC;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= SYNC;
            r_cnt         <= '0;
            r_conv_out    <= '0;
            r_conv_valid  <= 1'b0;
            r_sym_idx     <= '0;
            r_frame_start <= 1'b0;
            r_frame_err   <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_cnt         <= w_cnt_nxt;
            r_conv_valid  <= w_emit;
            r_frame_start <= w_start;
            r_frame_err   <= w_err;
            if (w_emit) begin
                r_conv_out <= w_sym;
                r_sym_idx  <= w_idx;
            end
        end
    end

    assign conv_out    = r_conv_out;
    assign conv_valid  = r_conv_valid;
    assign sym_idx     = r_sym_idx;
    assign frame_start = r_frame_start;
    assign frame_err   = r_frame_err;
    assign in_gap      = (r_state == GAP);

endmodule
